j_synch_rd: RTL and testbench
=============================

Name: j_synch_rd

Overview:
- Reader-side companion to the Jerry load-enable capture flops.
- Values are loaded at the writer end by (d, ld) strobes qualified by a clock-enable. This block captures them into a 2-entry skid store and presents them to a consumer over a valid/ack handshake.
- It flags a sticky overrun when the writer loads while the store is full.
- It sits between DSP-side register writes and slower consumers (e.g. I2S/serial sequencers) inside Jerry.

Parameters:
- WIDTH, 16, data width of d and q.
- ACK_PIPE, 0, 1 = register q_ack before use (adds one cycle to pop), 0 = use q_ack combinationally.

Ports:
- sys_clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- cken  input  1  writer clock-enable; ld is honoured only when cken=1.
- d  input  WIDTH  write data.
- ld  input  1  load strobe (push request).
- q  output  WIDTH  head-of-store data, valid when q_valid=1.
- q_valid  output  1  store non-empty.
- q_ack  input  1  consumer pop; ignored when q_valid=0.
- full  output  1  both entries occupied.
- ovr  output  1  sticky overrun flag.
- ovr_clr  input  1  synchronous clear of ovr.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - State EMPTY; q=0, q_valid=0, full=0, ovr=0.
  - ACK_PIPE register = 0.
  - Entries cleared to 0.
- push = ld & cken. pop = ack_eff & q_valid, where ack_eff = q_ack (ACK_PIPE=0) or the q_ack registered last cycle (ACK_PIPE=1).
- State machine EMPTY / ONE / TWO; entries head (h) and tail (t).
  - EMPTY: push -> h=d, go ONE. pop impossible.
  - ONE:
    - push & !pop -> t=d, go TWO.
    - pop & !push -> go EMPTY.
    - push & pop -> h=d, stay ONE.
  - TWO:
    - pop & !push -> h=t, go ONE.
    - push & pop -> h=t, t=d, stay TWO.
    - push & !pop -> overrun: data discarded, contents unchanged, ovr=1 next cycle.
- Outputs are registered from state:
  - q=h; q_valid = state!=EMPTY; full = state==TWO.
  - Latency: push in cycle N gives q_valid=1 and q=d in cycle N+1 when empty.
- ovr: set on overrun, cleared by ovr_clr. Simultaneous set and clear -> set wins (ovr=1).
- ld with cken=0 is ignored entirely and never causes overrun.
- Data is width-exact, no arithmetic. q holds its last value when EMPTY (not cleared except by reset).
- With ACK_PIPE=1, an ack registered while the store has since become empty is discarded.

Decomposition:
- Shared package j_synch_pkg:
  - state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - 2'd3 is illegal; it recovers to ST_EMPTY on the next clock.
- One sub-module: j_synch_ent, a WIDTH-bit load-enabled register with async clear. It is instantiated twice, for h and t.
- Control FSM and ovr logic stay in the top.

Test Plan:
- Reset release, no stimulus -> q_valid=0, full=0, ovr=0, q=0 for 10 cycles.
- cken=1, ld pulse d=16'hA5A5 in cycle 2 -> q_valid=1, q=A5A5 in cycle 3. q_ack in cycle 4 -> q_valid=0 in cycle 5, q still A5A5.
- Three pushes (0001, 0002, 0003) on consecutive cycles, no ack:
  - full=1 after the second push; ovr=1 after the third.
  - Two acks then return 0001, 0002; 0003 is lost.
  - ovr_clr asserted in the same cycle as a further overrun -> ovr stays 1. ovr_clr alone -> ovr=0.
- Full store, simultaneous push d=0004 and ack -> q advances to the old tail, tail=0004, full stays 1, no ovr.
- ld=1 with cken=0 while full -> no state change, ovr stays 0.
- Assert reset asynchronously mid-cycle while in TWO with q_ack high -> all outputs 0 before the next sys_clk edge. After release, first push behaves as from EMPTY. Repeat the handshake cases with ACK_PIPE=1 and check pop occurs one cycle later.

Source files
------------

// File: rtl/j_synch_pkg.sv
// Shared definitions for the Jerry load-enable reader: control state encoding.
package j_synch_pkg;

    // Encoding 2'd3 is unused and recovers to ST_EMPTY on the next clock.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/j_synch_rd_if.sv
// Writer/consumer bus of j_synch_rd: load strobes in, head data and status out.
interface j_synch_rd_if #(
    parameter int WIDTH = 16
);
    logic             cken;
    logic [WIDTH-1:0] d;
    logic             ld;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ack;
    logic             full;
    logic             ovr;
    logic             ovr_clr;

    // Master is the writer plus consumer; slave is the skid store itself.
    modport master (
        output cken, d, ld, q_ack, ovr_clr,
        input  q, q_valid, full, ovr
    );

    modport slave (
        input  cken, d, ld, q_ack, ovr_clr,
        output q, q_valid, full, ovr
    );
endinterface

// File: rtl/j_synch_ent.sv
// One entry of the skid store: WIDTH-bit load-enabled register, async clear.
module j_synch_ent #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: entries are plain flops, not a RAM, so clearing them on reset is legal and keeps q defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/j_synch_rd.sv
// Reader side of the Jerry load-enable flops: 2-entry skid store with
// valid/ack output and a sticky overrun flag.
module j_synch_rd
    import j_synch_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int ACK_PIPE = 0
) (
    input  logic        sys_clk,
    input  logic        reset,
    j_synch_rd_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic             push;
    logic             pop;
    logic             ack_q;
    logic             ack_eff;
    logic             ovr_set;
    logic             h_ld;
    logic             t_ld;
    logic [WIDTH-1:0] h_d;
    logic [WIDTH-1:0] h_q;
    logic [WIDTH-1:0] t_q;

    assign push    = bus.ld & bus.cken;
    assign ack_eff = (ACK_PIPE != 0) ? ack_q : bus.q_ack;
    // Gating with q_valid drops a piped ack that arrives after the store drained.
    assign pop     = ack_eff & bus.q_valid;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        h_ld      = 1'b0;
        t_ld      = 1'b0;
        h_d       = bus.d;
        ovr_set   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    h_ld      = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    h_ld = 1'b1;
                end else if (push) begin
                    t_ld      = 1'b1;
                    state_nxt = ST_TWO;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    h_ld = 1'b1;
                    h_d  = t_q;
                    t_ld = push;
                    if (!push) begin
                        state_nxt = ST_ONE;
                    end
                end else if (push) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_EMPTY;
            bus.q_valid <= 1'b0;
            bus.full    <= 1'b0;
            bus.ovr     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus.q_valid <= (state_nxt != ST_EMPTY);
            bus.full    <= (state_nxt == ST_TWO);
            bus.ovr     <= ovr_set | (bus.ovr & ~bus.ovr_clr);
            ack_q       <= bus.q_ack;
        end
    end

    j_synch_ent #(.WIDTH(WIDTH)) u_head (
        .clk (sys_clk),
        .rst (reset),
        .ld  (h_ld),
        .d   (h_d),
        .q   (h_q)
    );

    j_synch_ent #(.WIDTH(WIDTH)) u_tail (
        .clk (sys_clk),
        .rst (reset),
        .ld  (t_ld),
        .d   (bus.d),
        .q   (t_q)
    );

    assign bus.q = h_q;

endmodule

// File: tb/tb_j_synch_rd.sv
// Directed bench for j_synch_rd: one instance with combinational ack, one with piped ack.
module tb_j_synch_rd;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    j_synch_rd_if #(.WIDTH(WIDTH)) bus0 ();
    j_synch_rd_if #(.WIDTH(WIDTH)) bus1 ();

    j_synch_rd #(.WIDTH(WIDTH), .ACK_PIPE(0)) dut0 (
        .sys_clk (clk),
        .reset   (reset),
        .bus     (bus0)
    );

    j_synch_rd #(.WIDTH(WIDTH), .ACK_PIPE(1)) dut1 (
        .sys_clk (clk),
        .reset   (reset),
        .bus     (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic v, input logic f, input logic o,
                        input logic [WIDTH-1:0] qv);
        check({tag, ".q_valid0"}, {31'd0, bus0.q_valid}, {31'd0, v});
        check({tag, ".full0"},    {31'd0, bus0.full},    {31'd0, f});
        check({tag, ".ovr0"},     {31'd0, bus0.ovr},     {31'd0, o});
        check({tag, ".q0"},       {16'd0, bus0.q},       {16'd0, qv});
    endtask

    task automatic chk1(input string tag, input logic v, input logic f, input logic o,
                        input logic [WIDTH-1:0] qv);
        check({tag, ".q_valid1"}, {31'd0, bus1.q_valid}, {31'd0, v});
        check({tag, ".full1"},    {31'd0, bus1.full},    {31'd0, f});
        check({tag, ".ovr1"},     {31'd0, bus1.ovr},     {31'd0, o});
        check({tag, ".q1"},       {16'd0, bus1.q},       {16'd0, qv});
    endtask

    task automatic in0(input logic ck, input logic l, input logic [WIDTH-1:0] dv,
                       input logic ak, input logic cl);
        bus0.cken = ck; bus0.ld = l; bus0.d = dv; bus0.q_ack = ak; bus0.ovr_clr = cl;
    endtask

    task automatic in1(input logic ck, input logic l, input logic [WIDTH-1:0] dv,
                       input logic ak, input logic cl);
        bus1.cken = ck; bus1.ld = l; bus1.d = dv; bus1.q_ack = ak; bus1.ovr_clr = cl;
    endtask

    initial begin
        reset = 1'b1;
        in0(0, 0, 16'h0, 0, 0);
        in1(0, 0, 16'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset: both instances stay empty and cleared.
        for (int i = 0; i < 10; i++) begin
            step();
            chk0("idle", 0, 0, 0, 16'h0);
            chk1("idle", 0, 0, 0, 16'h0);
        end

        // ACK_PIPE=0: single push, one idle cycle, ack pops on the next edge.
        in0(1, 1, 16'hA5A5, 0, 0); step(); chk0("push1", 1, 0, 0, 16'hA5A5);
        in0(1, 0, 16'h0, 0, 0);    step(); chk0("hold1", 1, 0, 0, 16'hA5A5);
        in0(1, 0, 16'h0, 1, 0);    step(); chk0("pop1",  0, 0, 0, 16'hA5A5);

        // Three back-to-back pushes: full after two, overrun on the third.
        in0(1, 1, 16'h0001, 0, 0); step(); chk0("p1", 1, 0, 0, 16'h0001);
        in0(1, 1, 16'h0002, 0, 0); step(); chk0("p2", 1, 1, 0, 16'h0001);
        in0(1, 1, 16'h0003, 0, 0); step(); chk0("p3", 1, 1, 1, 16'h0001);
        // Overrun coinciding with clear: set wins.
        in0(1, 1, 16'h0009, 0, 1); step(); chk0("setwin", 1, 1, 1, 16'h0001);
        in0(1, 0, 16'h0, 0, 1);    step(); chk0("clr",    1, 1, 0, 16'h0001);
        in0(1, 0, 16'h0, 1, 0);    step(); chk0("ack_a",  1, 0, 0, 16'h0002);
        step();                            chk0("ack_b",  0, 0, 0, 16'h0002);

        // Full store, push and ack together: head takes old tail, no overrun.
        in0(1, 1, 16'h0005, 0, 0); step(); chk0("f5", 1, 0, 0, 16'h0005);
        in0(1, 1, 16'h0006, 0, 0); step(); chk0("f6", 1, 1, 0, 16'h0005);
        in0(1, 1, 16'h0004, 1, 0); step(); chk0("pp2", 1, 1, 0, 16'h0006);
        in0(1, 0, 16'h0, 1, 0);    step(); chk0("tail4", 1, 0, 0, 16'h0004);

        // Refill, then ld with cken=0 is ignored while full.
        in0(1, 1, 16'h0007, 0, 0); step(); chk0("f7", 1, 1, 0, 16'h0004);
        in0(0, 1, 16'h0008, 0, 0); step(); chk0("nocken_a", 1, 1, 0, 16'h0004);
        step();                            chk0("nocken_b", 1, 1, 0, 16'h0004);

        // Pop back to one entry, then push and pop together in ONE.
        in0(1, 0, 16'h0, 1, 0);    step(); chk0("pop7", 1, 0, 0, 16'h0007);
        in0(1, 1, 16'h000A, 1, 0); step(); chk0("pp1",  1, 0, 0, 16'h000A);
        in0(1, 1, 16'h000B, 0, 0); step(); chk0("fB",   1, 1, 0, 16'h000A);
        in0(1, 0, 16'h0, 0, 0);

        // ACK_PIPE=1: pop lands one cycle after the ack.
        in1(1, 1, 16'hA5A5, 0, 0); step(); chk1("push1", 1, 0, 0, 16'hA5A5);
        in1(1, 0, 16'h0, 1, 0);    step(); chk1("ackreg", 1, 0, 0, 16'hA5A5);
        in1(1, 0, 16'h0, 0, 0);    step(); chk1("pop1",  0, 0, 0, 16'hA5A5);

        in1(1, 1, 16'h0001, 0, 0); step(); chk1("p1", 1, 0, 0, 16'h0001);
        in1(1, 1, 16'h0002, 0, 0); step(); chk1("p2", 1, 1, 0, 16'h0001);
        in1(1, 1, 16'h0003, 0, 0); step(); chk1("p3", 1, 1, 1, 16'h0001);
        in1(1, 0, 16'h0, 1, 0);    step(); chk1("ack_a0", 1, 1, 1, 16'h0001);
        in1(1, 0, 16'h0, 0, 0);    step(); chk1("ack_a1", 1, 0, 1, 16'h0002);
        in1(1, 0, 16'h0, 1, 0);    step(); chk1("ack_b0", 1, 0, 1, 16'h0002);
        in1(1, 0, 16'h0, 0, 0);    step(); chk1("ack_b1", 0, 0, 1, 16'h0002);
        in1(1, 0, 16'h0, 0, 1);    step(); chk1("clr",    0, 0, 0, 16'h0002);

        // Held ack drains the store; the stale registered ack must not touch the next push.
        in1(1, 1, 16'h000D, 0, 0); step(); chk1("pD",    1, 0, 0, 16'h000D);
        in1(1, 0, 16'h0, 1, 0);    step(); chk1("hold0", 1, 0, 0, 16'h000D);
        step();                            chk1("drain", 0, 0, 0, 16'h000D);
        in1(1, 1, 16'h000E, 0, 0); step(); chk1("pE",    1, 0, 0, 16'h000E);
        in1(1, 0, 16'h0, 0, 0);    step(); chk1("keepE", 1, 0, 0, 16'h000E);

        // Async reset mid-cycle with dut0 in TWO and ack high: outputs clear before the next edge.
        in0(1, 0, 16'h0, 1, 0);
        #2 reset = 1'b1;
        #1;
        chk0("async_rst", 0, 0, 0, 16'h0);
        chk1("async_rst", 0, 0, 0, 16'h0);
        step();
        reset = 1'b0;
        in0(1, 1, 16'h00C3, 0, 0);
        in1(1, 1, 16'h003C, 0, 0);
        step();
        chk0("post_rst", 1, 0, 0, 16'h00C3);
        chk1("post_rst", 1, 0, 0, 16'h003C);
        in0(0, 0, 16'h0, 0, 0);
        in1(0, 0, 16'h0, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
